conv_interleaver_ctrl: RTL and testbench
========================================

// Module: conv_interleaver_ctrl
// PURPOSE
//  Commutator/scheduler for the convolutional byte interleaver (I branches, branch b = b*M-stage
//  8-bit delay line). Routes each accepted input byte to one branch, pulses that branch's shift
//  enable, and captures the byte that leaves that branch's line as the output byte.
//  Keeps the MPEG sync byte on branch 0, and flushes the delay lines with zero bytes on request.
//  Sits between the RS encoder output and the byte mapper. Branch delay lines are instantiated
//  outside this block. Branch 0 is a wire path inside this block.
// PARAMETERS
//  I      12   number of branches (commutator positions)
//  M      17   delay-line unit depth; branch b holds b*M bytes
//  DW     8    data width
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        input byte valid
//  in_ready   out  1        controller can accept a byte
//  in_sync    in   1        qualifies data_in as a packet sync byte
//  data_in    in   DW       input byte
//  flush_req  in   1        single-cycle request to drain the delay lines
//  line_data  out  DW       byte presented to every delay line input
//  branch_en  out  I        one-hot shift enable; bit b shifts branch b's line this edge
//  branch_q   in   I*DW     last-stage outputs of the branches; slice b = branch b (slice 0 unused)
//  out_valid  out  1        registered output byte valid
//  out_data   out  DW       interleaved output byte
//  out_sync   out  1        out_data is a sync byte
//  primed     out  1        all delay lines hold real (post-lock) data
//  sync_err   out  1        one-cycle pulse: sync seen while commutator was not at branch 0
// BEHAVIOUR
//  Reset values:
//   - state=SEARCH, branch index=0, fill count=0.
//   - out_valid, out_sync, primed, sync_err, out_data = 0; branch_en = 0.
//  Accept: accept = in_valid & in_ready. in_ready = 1 in SEARCH and RUN, 0 in FLUSH.
//  SEARCH state:
//   - Accepted non-sync bytes are dropped: branch_en=0 and no out_valid.
//   - An accepted byte with in_sync=1 goes to RUN. It is routed to branch 0 and the branch index
//     becomes 1.
//  RUN state, each accept:
//   - branch_en[b] is asserted combinationally (b = current index) and line_data=data_in.
//   - On that edge: out_data <= (b==0) ? data_in : branch_q[b] (the byte leaving the line).
//   - On that edge: out_valid <= 1 and out_sync <= in_sync & (b==0).
//   - The index advances mod I.
//   - Without an accept: branch_en=0 and out_valid <= 0. Latency is 1 clk from accept.
//  Resync: an accepted in_sync with index!=0 in RUN does the following:
//   - sync_err pulses.
//   - The byte is routed to branch 0 instead of branch b.
//   - The next index becomes 1.
//   - The fill count is not cleared.
//  Fill count:
//   - Increments per RUN/FLUSH branch shift and saturates at FILL=I*(I-1)*M (2244 by default).
//   - primed <= 1 when the count reaches FILL-1 and a shift occurs.
//  FLUSH state:
//   - Entered from RUN on flush_req. flush_req is ignored in SEARCH and FLUSH.
//   - Each clk: line_data=0 and branch_en is asserted for the current index, with the same
//     out_* capture as RUN. out_sync=0.
//   - Runs exactly FILL cycles, then goes to SEARCH. The index resets to 0 and primed and the
//     fill count clear.
//   - If flush_req and an accept happen in the same cycle, the byte is processed as RUN and
//     FLUSH starts on the next clk.
//  Width rules:
//   - The index counter is $clog2(I) bits and wraps I-1 -> 0.
//   - The fill counter is $clog2(FILL+1) bits.
//  Reset asserted mid-RUN or mid-FLUSH returns to the reset values on the next edge. Delay-line
//  contents are not cleared by this block.
// TESTING
//  T1 reset, then bytes 0x10..0x1F with no sync -> no branch_en, out_valid=0, still SEARCH.
//  T2 sync 0x47 then 0x01..0x0B -> branch_en walks 0x001,0x002..0x800; out_data(first)=0x47,
//     out_sync=1, 1-clk latency.
//  T3 continuous 204-byte packets (sync every 204 bytes), with a reference interleaver model ->
//     branch b output equals its input delayed b*M branch visits; primed rises after byte 2244;
//     sync_err stays 0.
//  T4 sync injected at index 5 -> sync_err pulses once, branch_en=0x001, next branch_en=0x002.
//  T5 flush_req after 3000 bytes -> in_ready=0 for 2244 clks, line_data=0, last real byte
//     emitted, then SEARCH, primed=0.
//  T6 reset asserted mid-FLUSH (cycle 100) -> next edge: SEARCH, branch_en=0, out_valid=0,
//     in_ready=1.

Source files
------------

// File: rtl/conv_interleaver_ctrl.sv
// Commutator/scheduler for a convolutional byte interleaver. Routes each accepted byte to one
// of I branches (branch b is an external b*M-stage delay line, branch 0 is a wire), pulses that
// branch's shift enable and registers the byte leaving the line as the output byte. Holds the
// packet sync byte on branch 0 and can drain the lines with zero bytes on request.
module conv_interleaver_ctrl #(
  parameter int unsigned I  = 12,
  parameter int unsigned M  = 17,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sync,
  input  logic [DW-1:0]   data_in,
  input  logic            flush_req,
  output logic [DW-1:0]   line_data,
  output logic [I-1:0]    branch_en,
  input  logic [I*DW-1:0] branch_q,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_sync,
  output logic            primed,
  output logic            sync_err
);

  localparam int unsigned Fill  = I * (I - 1) * M;
  localparam int unsigned IdxW  = $clog2(I);
  localparam int unsigned FillW = $clog2(Fill + 1);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(I - 1);
  localparam logic [FillW-1:0] FillMax  = FillW'(Fill);
  localparam logic [FillW-1:0] FillLast = FillW'(Fill - 1);

  typedef enum logic [1:0] {StSearch, StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d, sel;
  logic [FillW-1:0] fill_q, fill_d;
  logic [FillW-1:0] flush_cnt_q, flush_cnt_d;
  logic             primed_q, primed_d;
  logic             out_valid_q, out_sync_q, sync_err_q;
  logic [DW-1:0]    out_data_q;

  logic             accept, shift, resync, flush_done;
  logic             cap_sync;
  logic [DW-1:0]    cap_data;

  // Commutator FSM: picks the branch to shift this cycle and the next index/state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flush_cnt_d = flush_cnt_q;
    sel         = idx_q;
    shift       = 1'b0;
    resync      = 1'b0;
    flush_done  = 1'b0;
    in_ready    = (state_q != StFlush);
    accept      = in_valid & in_ready;
    line_data   = data_in;

    case (state_q)
      StSearch: begin
        // Only a sync byte locks the commutator; everything else is dropped.
        if (accept && in_sync) begin
          sel     = '0;
          shift   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          shift = 1'b1;
          // A sync byte off branch 0 realigns the commutator rather than being misrouted.
          if (in_sync && (idx_q != '0)) begin
            resync = 1'b1;
            sel    = '0;
          end
        end
        if (flush_req) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        line_data   = '0;
        shift       = 1'b1;
        flush_cnt_d = flush_cnt_q + FillW'(1);
        if (flush_cnt_q == FillLast) begin
          flush_done = 1'b1;
          state_d    = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase

    if (shift) begin
      idx_d = (sel == IdxLast) ? '0 : sel + IdxW'(1);
    end
    if (flush_done) begin
      idx_d = '0;
    end
  end

  // Shift enable, captured output byte and fill tracking for the selected branch.
  always_comb begin
    branch_en = '0;
    if (shift) begin
      branch_en[sel] = 1'b1;
    end
    cap_data = (sel == '0) ? line_data : branch_q[DW*int'(sel) +: DW];
    cap_sync = shift && (state_q != StFlush) && in_sync && (sel == '0);

    fill_d   = fill_q;
    primed_d = primed_q;
    if (shift) begin
      if (fill_q != FillMax) begin
        fill_d = fill_q + FillW'(1);
      end
      if (fill_q == FillLast) begin
        primed_d = 1'b1;
      end
    end
    // Lines now hold only flush zeros, so nothing real is buffered any more.
    if (flush_done) begin
      fill_d   = '0;
      primed_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      idx_q       <= '0;
      fill_q      <= '0;
      flush_cnt_q <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      flush_cnt_q <= flush_cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= shift;
      out_sync_q  <= cap_sync;
      sync_err_q  <= resync;
      if (shift) begin
        out_data_q <= cap_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sync  = out_sync_q;
  assign primed    = primed_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_conv_interleaver_ctrl.sv
// Bench for conv_interleaver_ctrl: behavioural branch delay lines around the DUT, a directed
// vector table for search/lock, and a queue-history reference model for long streams.
module tb_conv_interleaver_ctrl;

  localparam int I    = 12;
  localparam int M    = 17;
  localparam int DW   = 8;
  localparam int FILL = I * (I - 1) * M;
  localparam int LMAX = (I - 1) * M;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, in_sync, flush_req;
  logic          out_valid, out_sync, primed, sync_err;
  logic [7:0]    data_in, line_data, out_data;
  logic [11:0]   branch_en;
  logic [95:0]   branch_q;
  logic          dl_clr;

  always #5 clk = ~clk;

  conv_interleaver_ctrl #(.I(I), .M(M), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sync   (in_sync),
    .data_in   (data_in),
    .flush_req (flush_req),
    .line_data (line_data),
    .branch_en (branch_en),
    .branch_q  (branch_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sync  (out_sync),
    .primed    (primed),
    .sync_err  (sync_err)
  );

  // Branch delay lines: branch b holds b*M bytes.
  logic [7:0] dl [I][LMAX];
  always @(posedge clk) begin
    for (int b = 1; b < I; b++) begin
      if (dl_clr) begin
        for (int k = 0; k < LMAX; k++) dl[b][k] <= 8'h00;
      end else if (branch_en[b]) begin
        dl[b][0] <= line_data;
        for (int k = 1; k < LMAX; k++) if (k < b * M) dl[b][k] <= dl[b][k-1];
      end
    end
  end
  always_comb begin
    branch_q = '0;
    for (int b = 1; b < I; b++) branch_q[b*8 +: 8] = dl[b][b*M-1];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int         m_state;  // 0 search, 1 run, 2 flush
  int         m_idx, m_fill, m_fcnt;
  logic       m_primed;
  logic [7:0] hist [I][2048];
  int         hcnt [I];
  int         pk, nb;
  logic [11:0] obs_en;
  logic        obs_rdy, obs_err;

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_fill = 0; m_fcnt = 0; m_primed = 1'b0;
    for (int b = 0; b < I; b++) hcnt[b] = 0;
    pk = 0; nb = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; dl_clr = 1'b1;
    in_valid = 1'b0; in_sync = 1'b0; flush_req = 1'b0; data_in = 8'h00;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0; dl_clr = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus, checked against the reference model.
  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic f);
    int         b, n;
    logic       erdy, acc, eos, eerr;
    logic [11:0] een;
    logic [7:0] eline, eod;
    in_valid = v; in_sync = s; data_in = d; flush_req = f;
    #1;
    erdy = (m_state != 2);
    acc  = v && erdy;
    b = -1; eos = 1'b0; eerr = 1'b0; een = '0;
    eline = (m_state == 2) ? 8'h00 : d;
    case (m_state)
      0: if (acc && s) begin b = 0; eos = 1'b1; end
      1: if (acc) begin
        if (s && m_idx != 0) begin b = 0; eerr = 1'b1; end
        else b = m_idx;
        eos = s;
      end
      default: b = m_idx;
    endcase
    if (b >= 0) een[b] = 1'b1;
    obs_en  = branch_en;
    obs_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk("branch_en", 32'(branch_en), 32'(een));
    chk("line_data", 32'(line_data), 32'(eline));
    eod = 8'h00;
    if (b == 0) eod = eline;
    else if (b > 0) begin
      n = hcnt[b];
      eod = (n >= b * M) ? hist[b][n - b*M] : 8'h00;
      hist[b][n] = eline;
      hcnt[b] = n + 1;
    end
    @(posedge clk);
    #1;
    obs_err = sync_err;
    chk("out_valid", 32'(out_valid), 32'(b >= 0));
    if (b >= 0) begin
      chk("out_data", 32'(out_data), 32'(eod));
      chk("out_sync", 32'(out_sync), 32'(eos));
    end
    chk("sync_err", 32'(sync_err), 32'(eerr));
    if (b >= 0) begin
      if (m_fill == FILL - 1) m_primed = 1'b1;
      if (m_fill < FILL) m_fill++;
    end
    case (m_state)
      0: if (b == 0) begin m_state = 1; m_idx = 1; end
      1: begin
        if (b >= 0) m_idx = (b + 1) % I;
        if (f) begin m_state = 2; m_fcnt = 0; end
      end
      default: begin
        m_idx = (m_idx + 1) % I;
        m_fcnt++;
        if (m_fcnt == FILL) begin
          m_state = 0; m_idx = 0; m_fill = 0; m_primed = 1'b0;
        end
      end
    endcase
    chk("primed", 32'(primed), 32'(m_primed));
  endtask

  // 204-byte packets with periodic idle cycles.
  task automatic run_bytes(input int n);
    int   sent, cyc;
    logic s;
    sent = 0; cyc = 0;
    while (sent < n) begin
      if (cyc % 13 == 12) drive(1'b0, 1'b0, 8'hEE, 1'b0);
      else begin
        s = (pk == 0);
        drive(1'b1, s, s ? 8'h47 : 8'(nb * 7 + 3), 1'b0);
        pk = (pk + 1) % 204;
        nb++;
        sent++;
        if (nb == FILL - 1) chk("primed_before_fill", 32'(primed), 32'd0);
        if (nb == FILL)     chk("primed_at_fill", 32'(primed), 32'd1);
      end
      cyc++;
    end
  endtask

  typedef struct {
    logic        v, s;
    logic [7:0]  d;
    logic [11:0] en;
    logic        ov, os;
    logic [7:0]  od;
  } vec_t;

  function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic [11:0] en, logic ov,
                              logic [7:0] od, logic os);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.en = en; r.ov = ov; r.od = od; r.os = os;
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [30];
    int   low;
    logic [11:0] one;

    do_reset(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sync", 32'(out_sync), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_branch_en", 32'(branch_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Search drops non-sync bytes; sync locks and the commutator walks all branches.
    for (int k = 0; k < 16; k++) tbl[k] = mk(1'b1, 1'b0, 8'(8'h10 + k), 12'h000, 1'b0, 8'h00, 1'b0);
    tbl[16] = mk(1'b1, 1'b1, 8'h47, 12'h001, 1'b1, 8'h47, 1'b1);
    for (int k = 1; k < 12; k++) begin
      one = 12'h001 << k;
      tbl[16 + k] = mk(1'b1, 1'b0, 8'(k), one, 1'b1, 8'h00, 1'b0);
    end
    tbl[28] = mk(1'b0, 1'b0, 8'h77, 12'h000, 1'b0, 8'h00, 1'b0);
    tbl[29] = mk(1'b1, 1'b0, 8'h0C, 12'h001, 1'b1, 8'h0C, 1'b0);
    for (int k = 0; k < 30; k++) begin
      in_valid = tbl[k].v; in_sync = tbl[k].s; data_in = tbl[k].d; flush_req = 1'b0;
      #1;
      chk("tbl_branch_en", 32'(branch_en), 32'(tbl[k].en));
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      chk("tbl_line_data", 32'(line_data), 32'(tbl[k].d));
      @(posedge clk);
      #1;
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[k].ov));
      if (tbl[k].ov) begin
        chk("tbl_out_data", 32'(out_data), 32'(tbl[k].od));
        chk("tbl_out_sync", 32'(out_sync), 32'(tbl[k].os));
      end
      chk("tbl_sync_err", 32'(sync_err), 32'd0);
    end

    // Long packet stream through the full interleaver.
    do_reset(1);
    run_bytes(2600);

    // Sync arriving at branch 5 realigns to branch 0.
    for (int k = 0; k < 12 && m_idx != 5; k++) begin
      drive(1'b1, 1'b0, 8'(8'hC0 + k), 1'b0);
      pk = (pk + 1) % 204; nb++;
    end
    drive(1'b1, 1'b1, 8'h47, 1'b0);
    chk("resync_branch_en", 32'(obs_en), 32'h001);
    chk("resync_err_pulse", 32'(obs_err), 32'd1);
    pk = 1; nb++;
    drive(1'b1, 1'b0, 8'h33, 1'b0);
    chk("resync_next_en", 32'(obs_en), 32'h002);
    chk("resync_err_single", 32'(obs_err), 32'd0);
    pk = 2; nb++;

    // Flush after 3000 bytes; flush_req coincides with an accepted byte.
    run_bytes(3000 - nb);
    drive(1'b1, 1'b0, 8'h5A, 1'b1);
    low = 0;
    for (int k = 0; k < FILL; k++) begin
      drive(1'b1, 1'b0, 8'h99, k == 10);
      if (!obs_rdy) low++;
    end
    chk("flush_len", 32'(low), 32'(FILL));
    drive(1'b1, 1'b0, 8'h12, 1'b0);
    chk("post_flush_ready", 32'(obs_rdy), 32'd1);
    chk("post_flush_en", 32'(obs_en), 32'd0);
    chk("post_flush_primed", 32'(primed), 32'd0);

    // Reset in the middle of a flush.
    do_reset(1);
    run_bytes(21);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (100) drive(1'b0, 1'b0, 8'h00, 1'b0);
    in_valid = 1'b1; in_sync = 1'b0; data_in = 8'h21; flush_req = 1'b0;
    reset = 1'b1; dl_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_branch_en", 32'(branch_en), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_primed", 32'(primed), 32'd0);
    reset = 1'b0; dl_clr = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 8'h21, 1'b0);
    chk("midrst_drop_en", 32'(obs_en), 32'd0);
    drive(1'b1, 1'b1, 8'h47, 1'b0);
    chk("midrst_relock_en", 32'(obs_en), 32'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
